// File: rtl/osc_input_events_pkg.sv
// Shared constants for the oscilloscope input front end:
// PS/2 set-2 scancodes, event bit indices, PS/2 RX FSM states.
package osc_input_events_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_ENTER = 8'h5A;

   localparam int EV_UP    = 0;
   localparam int EV_DOWN  = 1;
   localparam int EV_LEFT  = 2;
   localparam int EV_RIGHT = 3;
   localparam int EV_OK    = 4;
   localparam int NEV      = 5;

   typedef enum logic [1:0] {
      PS2_IDLE,
      PS2_DATA,
      PS2_PARITY,
      PS2_STOP
   } ps2_state_t;

   // 1 when data plus parity bit hold an odd number of ones
   function automatic logic odd_ok(input logic [7:0] d,
                                   input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/osc_input_events_if.sv
// Raw inputs (buttons, PS/2 kc/kd) and event pulse outputs.
// master drives the raw inputs, slave is the event front end.
interface osc_input_events_if;

   logic [3:0] btns;
   logic       kc;
   logic       kd;
   logic       ev_up_pe;
   logic       ev_down_pe;
   logic       ev_left_pe;
   logic       ev_right_pe;
   logic       ev_ok_pe;
   logic       ps2_err_pe;

   modport master (
      output btns, kc, kd,
      input  ev_up_pe, ev_down_pe, ev_left_pe,
      input  ev_right_pe, ev_ok_pe, ps2_err_pe
   );

   modport slave (
      input  btns, kc, kd,
      output ev_up_pe, ev_down_pe, ev_left_pe,
      output ev_right_pe, ev_ok_pe, ps2_err_pe
   );

endinterface

// File: rtl/osc_input_events_ps2_rx.sv
// PS/2 receiver: kc/kd sync, kc falling edge, 11-bit frame FSM, timeout.
// Ports: kc_i/kd_i raw; byte_o + valid_o (1 cycle); err_o (1 cycle drop).
module osc_input_events_ps2_rx
   import osc_input_events_pkg::*;
#(
   parameter int PS2_TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kc_i,
   input  logic       kd_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       err_o
);

   localparam int TW = $clog2(PS2_TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(PS2_TIMEOUT_CYCLES - 1);

   logic          kc1_q, kc2_q, kc3_q;
   logic          kd1_q, kd2_q;
   logic          kc_fe;

   ps2_state_t    state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_q, to_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;

   // PS/2 lines idle high, so the synchronizers reset high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kc1_q <= 1'b1;
         kc2_q <= 1'b1;
         kc3_q <= 1'b1;
         kd1_q <= 1'b1;
         kd2_q <= 1'b1;
      end else begin
         kc1_q <= kc_i;
         kc2_q <= kc1_q;
         kc3_q <= kc2_q;
         kd1_q <= kd_i;
         kd2_q <= kd1_q;
      end
   end

   assign kc_fe = kc3_q & ~kc2_q;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      par_d   = par_q;
      to_d    = '0;
      byte_d  = byte_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      if (state_q != PS2_IDLE && !kc_fe)
         to_d = to_q + 1'b1;

      unique case (state_q)
         PS2_IDLE: begin
            if (kc_fe) begin
               if (!kd2_q) begin
                  state_d = PS2_DATA;
                  bit_d   = 3'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         PS2_DATA: begin
            if (kc_fe) begin
               sh_d  = {kd2_q, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7)
                  state_d = PS2_PARITY;
            end
         end
         PS2_PARITY: begin
            if (kc_fe) begin
               par_d   = kd2_q;
               state_d = PS2_STOP;
            end
         end
         PS2_STOP: begin
            if (kc_fe) begin
               state_d = PS2_IDLE;
               if (kd2_q && odd_ok(sh_q, par_q)) begin
                  valid_d = 1'b1;
                  byte_d  = sh_q;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      endcase

      // stalled frame: keyboard stopped clocking mid-frame
      if (state_q != PS2_IDLE && !kc_fe && to_q == TO_LAST) begin
         state_d = PS2_IDLE;
         err_d   = 1'b1;
         to_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= PS2_IDLE;
         bit_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         to_q    <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         to_q    <= to_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign byte_o  = byte_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

endmodule

// File: rtl/osc_input_events.sv
// Menu input front end: debounced buttons + PS/2 scancodes -> event pulses.
// Ports: clk, rst (async active-low), bus (slave: btns/kc/kd in, ev_*_pe out).
module osc_input_events
   import osc_input_events_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES    = 500000,
   parameter int PS2_TIMEOUT_CYCLES = 50000
) (
   input  logic               clk,
   input  logic               rst,
   osc_input_events_if.slave  bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]     bs1_q, bs2_q;
   logic [3:0]     stable;
   logic [3:0]     prev_q;
   logic [3:0]     btn_rise;
   logic [NEV-1:0] btn_ev;
   logic [NEV-1:0] kbd_ev;
   logic [NEV-1:0] ev_q;

   logic [7:0]     rx_byte;
   logic           rx_valid;
   logic           rx_err;
   logic           ext_q, ext_d;
   logic           brk_q, brk_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bs1_q <= '0;
         bs2_q <= '0;
      end else begin
         bs1_q <= bus.btns;
         bs2_q <= bs1_q;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_db
      logic [DW-1:0] cnt_q, cnt_d;
      logic          st_q, st_d;

      always_comb begin
         st_d  = st_q;
         cnt_d = '0;
         if (bs2_q[g] != st_q) begin
            if (cnt_q == DB_LAST)
               st_d = bs2_q[g];
            else
               cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q <= '0;
            st_q  <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            st_q  <= st_d;
         end
      end

      assign stable[g] = st_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         prev_q <= '0;
      else
         prev_q <= stable;
   end

   assign btn_rise = stable & ~prev_q;

   always_comb begin
      btn_ev           = '0;
      btn_ev[EV_UP]    = btn_rise[0];
      btn_ev[EV_DOWN]  = btn_rise[1];
      btn_ev[EV_OK]    = btn_rise[2];
      btn_ev[EV_LEFT]  = btn_rise[3];
   end

   osc_input_events_ps2_rx #(
      .PS2_TIMEOUT_CYCLES (PS2_TIMEOUT_CYCLES)
   ) u_rx (
      .clk     (clk),
      .rst     (rst),
      .kc_i    (bus.kc),
      .kd_i    (bus.kd),
      .byte_o  (rx_byte),
      .valid_o (rx_valid),
      .err_o   (rx_err)
   );

   // E0/F0 are prefixes; a make code consumes ext, a break consumes both
   always_comb begin
      ext_d  = ext_q;
      brk_d  = brk_q;
      kbd_ev = '0;
      if (rx_valid) begin
         if (rx_byte == SC_EXT) begin
            ext_d = 1'b1;
         end else if (rx_byte == SC_BRK) begin
            brk_d = 1'b1;
         end else if (brk_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
         end else begin
            ext_d = 1'b0;
            unique case (1'b1)
               (ext_q && rx_byte == SC_UP):
                  kbd_ev[EV_UP] = 1'b1;
               (ext_q && rx_byte == SC_DOWN):
                  kbd_ev[EV_DOWN] = 1'b1;
               (ext_q && rx_byte == SC_LEFT):
                  kbd_ev[EV_LEFT] = 1'b1;
               (ext_q && rx_byte == SC_RIGHT):
                  kbd_ev[EV_RIGHT] = 1'b1;
               (!ext_q && rx_byte == SC_ENTER):
                  kbd_ev[EV_OK] = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
         ev_q  <= '0;
      end else begin
         ext_q <= ext_d;
         brk_q <= brk_d;
         ev_q  <= btn_ev | kbd_ev;
      end
   end

   assign bus.ev_up_pe    = ev_q[EV_UP];
   assign bus.ev_down_pe  = ev_q[EV_DOWN];
   assign bus.ev_left_pe  = ev_q[EV_LEFT];
   assign bus.ev_right_pe = ev_q[EV_RIGHT];
   assign bus.ev_ok_pe    = ev_q[EV_OK];
   assign bus.ps2_err_pe  = rx_err;

endmodule
